// File: rtl/mod_arith_seq.sv
// mod_arith_seq: handshaked sequential arithmetic engine (ADD, MULT, CAT, MAC).
// A shift-add multiplier retires one bit of b per cycle. A persistent accumulator
// with a sticky overflow flag backs MAC.
// Optional build macro MOD_ARITH_SIGNED_OPS_EN selects two's-complement ADD/MULT/MAC.
module mod_arith_seq #(
  parameter int unsigned WIDTH     = 10,
  parameter int unsigned ACC_WIDTH = 2 * WIDTH + 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 acc_clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 busy,
  output logic                 overflow
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [2:0] {StIdle, StExec, StMul, StAcc, StResp} state_e;
  typedef enum logic [1:0] {OpAdd = 2'd0, OpMult = 2'd1, OpCat = 2'd2, OpMac = 2'd3} op_e;

  state_e               state_q;
  op_e                  op_q;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [PW-1:0]        mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [PW-1:0]        prod_q;
  logic [CW-1:0]        cnt_q;
  logic                 neg_q;
  logic [ACC_WIDTH-1:0] acc_q;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic                 neg_d;
  logic [PW-1:0]        prod_nx;
  logic [ACC_WIDTH-1:0] mul_res, addend, exec_res;
  logic [ACC_WIDTH:0]   acc_sum;
  logic                 acc_ovf;

  // Applies the deferred sign to a magnitude product and widens it to ACC_WIDTH.
  function automatic logic [ACC_WIDTH-1:0] finish(input logic [PW-1:0] p, input logic neg);
    logic [ACC_WIDTH-1:0] ext;
    ext = ACC_WIDTH'(p);
    if (neg) ext = -ext;
    return ext;
  endfunction

  // Operand magnitudes, product step, EXEC result and accumulator add.
  always_comb begin
`ifdef MOD_ARITH_SIGNED_OPS_EN
    a_mag    = a[WIDTH-1] ? -a : a;
    b_mag    = b[WIDTH-1] ? -b : b;
    neg_d    = a[WIDTH-1] ^ b[WIDTH-1];
    exec_res = (op_q == OpAdd) ? ACC_WIDTH'($signed(a_q)) + ACC_WIDTH'($signed(b_q))
                               : ACC_WIDTH'({a_q, b_q});
`else
    a_mag    = a;
    b_mag    = b;
    neg_d    = 1'b0;
    exec_res = (op_q == OpAdd) ? ACC_WIDTH'(a_q) + ACC_WIDTH'(b_q)
                               : ACC_WIDTH'({a_q, b_q});
`endif
    prod_nx = prod_q + (mplier_q[0] ? mcand_q : '0);
    mul_res = finish(prod_nx, neg_q);
    addend  = finish(prod_q, neg_q);
    acc_sum = {1'b0, acc_q} + {1'b0, addend};
`ifdef MOD_ARITH_SIGNED_OPS_EN
    // Signed overflow: carry into the MSB differs from carry out of it.
    acc_ovf = acc_sum[ACC_WIDTH] ^ acc_sum[ACC_WIDTH-1] ^ acc_q[ACC_WIDTH-1]
              ^ addend[ACC_WIDTH-1];
`else
    acc_ovf = acc_sum[ACC_WIDTH];
`endif
  end

  // Command FSM with registered handshake outputs, multiplier datapath and accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      op_q      <= OpAdd;
      a_q       <= '0;
      b_q       <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            op_q     <= op_e'(op);
            a_q      <= a;
            b_q      <= b;
            mcand_q  <= PW'(a_mag);
            mplier_q <= b_mag;
            prod_q   <= '0;
            cnt_q    <= '0;
            neg_q    <= neg_d;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            // Clear precedes any MAC add of this same command.
            if (acc_clr) begin
              acc_q    <= '0;
              overflow <= 1'b0;
            end
            state_q <= (op_e'(op) == OpAdd || op_e'(op) == OpCat) ? StExec : StMul;
          end
        end
        StExec: begin
          result    <= exec_res;
          out_valid <= 1'b1;
          state_q   <= StResp;
        end
        StMul: begin
          prod_q   <= prod_nx;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            if (op_q == OpMac) begin
              state_q <= StAcc;
            end else begin
              result    <= mul_res;
              out_valid <= 1'b1;
              state_q   <= StResp;
            end
          end
        end
        StAcc: begin
          acc_q     <= acc_sum[ACC_WIDTH-1:0];
          result    <= acc_sum[ACC_WIDTH-1:0];
          overflow  <= overflow | acc_ovf;
          out_valid <= 1'b1;
          state_q   <= StResp;
        end
        StResp: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
